data_mem_sized_51: RTL and testbench

// Parametrised word-organised data memory for the MIPS datapath, successor to the fixed 2001-word memory.

---
 rtl/data_mem_sized_51.sv | 153 +++++++++++++++
 tb/tb_data_mem_sized_51.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_sized_51.sv
// Byte-addressed data memory with byte/half/word access, registered load path and a
// reset-time clear sweep. One request per cycle; errors reported as a one-cycle pulse.
module data_mem_sized_51 #(
    parameter int unsigned DEPTH          = 2048,
    parameter int unsigned ADDR_W         = 32,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk_51,
    input  logic              rst_51,
    input  logic              req_51,
    input  logic              we_51,
    input  logic [1:0]        size_51,
    input  logic              sext_51,
    input  logic [ADDR_W-1:0] addr_51,
    input  logic [31:0]       wdata_51,
    output logic [31:0]       rdata_51,
    output logic              rvalid_51,
    output logic              err_51,
    output logic              ready_51
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] clr_idx_q;
    logic             ready_q;
    logic             rvalid_q;
    logic             err_q;
    logic [31:0]      rdata_q;

    logic [31:0]      mem [DEPTH];

    logic [ADDR_W-1:0] word_full;
    logic [IDX_W-1:0]  word_idx;
    logic              bad;
    logic              accept;
    logic              store_ok;
    logic [3:0]        be;
    logic [31:0]       mask;
    logic [31:0]       wword;
    logic [31:0]       rword;
    logic [31:0]       merged;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       load_val;

    assign word_full = {2'b00, addr_51[ADDR_W-1:2]};
    assign word_idx  = word_full[IDX_W-1:0];
    assign rword     = mem[word_idx];

    // Alignment, reserved size and range checks all collapse into one reject flag.
    always_comb begin
        bad = 1'b0;
        case (size_51)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr_51[0];
            2'b10:   bad = |addr_51[1:0];
            default: bad = 1'b1;
        endcase
        if (word_full >= ADDR_W'(DEPTH)) begin
            bad = 1'b1;
        end
    end

    assign accept   = req_51 && ready_q;
    assign store_ok = accept && we_51 && !bad;

    always_comb begin
        be    = 4'b1111;
        wword = wdata_51;
        case (size_51)
            2'b00: begin
                be    = 4'b0001 << addr_51[1:0];
                wword = {4{wdata_51[7:0]}};
            end
            2'b01: begin
                be    = addr_51[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata_51[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wword = wdata_51;
            end
        endcase
    end

    assign mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign merged = (rword & ~mask) | (wword & mask);

    assign lane_b = rword[{addr_51[1:0], 3'b000} +: 8];
    assign lane_h = rword[{addr_51[1], 4'b0000} +: 16];

    always_comb begin
        case (size_51)
            2'b00:   load_val = {{24{sext_51 & lane_b[7]}}, lane_b};
            2'b01:   load_val = {{16{sext_51 & lane_h[15]}}, lane_h};
            default: load_val = rword;
        endcase
    end

    // Storage has no reset; while rst_51 is high nothing is written.
    always_ff @(posedge clk_51) begin
        if (!rst_51) begin
            if (state_q == StClear) begin
                mem[clr_idx_q] <= '0;
            end else if (store_ok) begin
                mem[word_idx] <= merged;
            end
        end
    end

    always_ff @(posedge clk_51 or posedge rst_51) begin
        if (rst_51) begin
            state_q   <= CLEAR_ON_RESET ? StClear : StRun;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                StClear: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                        ready_q <= 1'b1;
                        state_q <= StRun;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (bad) begin
                            err_q <= 1'b1;
                        end else if (!we_51) begin
                            rdata_q  <= load_val;
                            rvalid_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign rdata_51  = rdata_q;
    assign rvalid_51 = rvalid_q;
    assign err_51    = err_q;
    assign ready_51  = ready_q;

endmodule

// File: tb/tb_data_mem_sized_51.sv
// Self-checking bench: a DEPTH=16 instance with the clear sweep and one without,
// checked by directed tables and a byte-array reference model under random traffic.
module tb_data_mem_sized_51;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        rst_b;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [31:0] a_rdata, b_rdata;
    logic        a_rvalid, b_rvalid, a_err, b_err, a_ready, b_ready;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem_m [DEPTH*4];
    logic [31:0] model_rd = '0;

    typedef struct packed {
        logic        rq;
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rv;
        logic        er;
        logic [31:0] rd;
    } row_t;

    always #5 clk = ~clk;

    data_mem_sized_51 #(.DEPTH(DEPTH), .ADDR_W(32), .CLEAR_ON_RESET(1'b1)) dut_a (
        .clk_51(clk), .rst_51(rst_a), .req_51(req), .we_51(we), .size_51(size),
        .sext_51(sext), .addr_51(addr), .wdata_51(wdata), .rdata_51(a_rdata),
        .rvalid_51(a_rvalid), .err_51(a_err), .ready_51(a_ready)
    );

    data_mem_sized_51 #(.DEPTH(DEPTH), .ADDR_W(32), .CLEAR_ON_RESET(1'b0)) dut_b (
        .clk_51(clk), .rst_51(rst_b), .req_51(req), .we_51(we), .size_51(size),
        .sext_51(sext), .addr_51(addr), .wdata_51(wdata), .rdata_51(b_rdata),
        .rvalid_51(b_rvalid), .err_51(b_err), .ready_51(b_ready)
    );

    function automatic bit m_bad(input logic [1:0] sz, input int unsigned ad);
        int unsigned n;
        if (sz == 2'd3) return 1'b1;
        n = 1 << sz;
        if ((ad % n) != 0) return 1'b1;
        return (ad / 4) >= DEPTH;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sx,
                                           input int unsigned ad);
        int unsigned n = 1 << sz;
        logic [31:0] v = '0;
        for (int j = 0; j < int'(n); j++) v[8*j +: 8] = mem_m[ad + j];
        if (sx && n < 4 && v[8*n-1]) begin
            for (int k = 8 * int'(n); k < 32; k++) v[k] = 1'b1;
        end
        return v;
    endfunction

    task automatic m_store(input logic [1:0] sz, input int unsigned ad, input logic [31:0] wd);
        int unsigned n = 1 << sz;
        for (int j = 0; j < int'(n); j++) mem_m[ad + j] = wd[8*j +: 8];
    endtask

    // Presents one request for exactly one edge; outputs are sampled 1 time unit later.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] ad, input logic [31:0] wd);
        req = 1'b1; we = w; size = sz; sext = sx; addr = ad; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; req = 1'b0; we = 1'b0; size = 2'd2; sext = 1'b0;
        addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", a_ready); end
        checks++; if (a_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", a_rvalid); end
        checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", a_err); end
        checks++; if (a_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", a_rdata); end
        // A load held during the sweep must be ignored.
        req = 1'b1; we = 1'b0; size = 2'd2; addr = 32'h3C;
        rst_a = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            checks++;
            if (a_ready !== (i == 16)) begin
                failures++; $display("FAIL sweep_ready edge=%0d got=%b exp=%b", i, a_ready, i == 16);
            end
            checks++;
            if (a_rvalid !== 1'b0 || a_err !== 1'b0) begin
                failures++; $display("FAIL sweep_ignore edge=%0d rvalid=%b err=%b exp=0", i, a_rvalid, a_err);
            end
        end
        req = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 32'h3C, 32'h0);
        checks++; if (a_rvalid !== 1'b1) begin failures++; $display("FAIL clr_load_rvalid got=%b exp=1", a_rvalid); end
        checks++; if (a_rdata !== 32'h0) begin failures++; $display("FAIL clr_load_rdata got=%h exp=0", a_rdata); end
        @(posedge clk); #1;
        checks++; if (a_rvalid !== 1'b0) begin failures++; $display("FAIL rvalid_pulse got=%b exp=0", a_rvalid); end
    endtask

    task automatic test_lanes();
        row_t rows [8];
        rows = '{
            '{1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hA1B2C3D4, 1'b0, 1'b0, 32'h00000000},
            '{1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        1'b1, 1'b0, 32'hFFFFFFA1},
            '{1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        1'b1, 1'b0, 32'h000000A1},
            '{1'b1, 1'b0, 2'd1, 1'b1, 32'h10, 32'h0,        1'b1, 1'b0, 32'hFFFFC3D4},
            '{1'b1, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        1'b1, 1'b0, 32'h0000A1B2},
            '{1'b1, 1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF5A, 1'b0, 1'b0, 32'h0000A1B2},
            '{1'b1, 1'b0, 2'd2, 1'b1, 32'h10, 32'h0,        1'b1, 1'b0, 32'hA1B25AD4},
            '{1'b1, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0,        1'b1, 1'b0, 32'h0000005A}
        };
        for (int i = 0; i < 8; i++) begin
            issue(rows[i].we, rows[i].size, rows[i].sext, rows[i].addr, rows[i].wdata);
            checks++;
            if (a_rvalid !== rows[i].rv) begin failures++; $display("FAIL lanes_rvalid row=%0d got=%b exp=%b", i, a_rvalid, rows[i].rv); end
            checks++;
            if (a_err !== rows[i].er) begin failures++; $display("FAIL lanes_err row=%0d got=%b exp=%b", i, a_err, rows[i].er); end
            checks++;
            if (a_rdata !== rows[i].rd) begin failures++; $display("FAIL lanes_rdata row=%0d got=%h exp=%h", i, a_rdata, rows[i].rd); end
        end
    endtask

    task automatic test_errors();
        row_t rows [9];
        rows = '{
            '{1'b1, 1'b0, 2'd2, 1'b0, 32'h12, 32'h0,        1'b0, 1'b1, 32'h0000005A},
            '{1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0000005A},
            '{1'b1, 1'b0, 2'd1, 1'b1, 32'h11, 32'h0,        1'b0, 1'b1, 32'h0000005A},
            '{1'b1, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        1'b0, 1'b1, 32'h0000005A},
            '{1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        1'b0, 1'b1, 32'h0000005A},
            '{1'b1, 1'b1, 2'd2, 1'b0, 32'h12, 32'h11111111, 1'b0, 1'b1, 32'h0000005A},
            '{1'b1, 1'b1, 2'd0, 1'b0, 32'h40, 32'h000000FF, 1'b0, 1'b1, 32'h0000005A},
            '{1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0000005A},
            '{1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 32'hA1B25AD4}
        };
        for (int i = 0; i < 9; i++) begin
            if (rows[i].rq) issue(rows[i].we, rows[i].size, rows[i].sext, rows[i].addr, rows[i].wdata);
            else begin @(posedge clk); #1; end
            checks++;
            if (a_rvalid !== rows[i].rv) begin failures++; $display("FAIL err_rvalid row=%0d got=%b exp=%b", i, a_rvalid, rows[i].rv); end
            checks++;
            if (a_err !== rows[i].er) begin failures++; $display("FAIL err_err row=%0d got=%b exp=%b", i, a_err, rows[i].er); end
            checks++;
            if (a_rdata !== rows[i].rd) begin failures++; $display("FAIL err_rdata row=%0d got=%h exp=%h", i, a_rdata, rows[i].rd); end
        end
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        checks++; if (a_rdata !== 32'hDEADBEEF || a_rvalid !== 1'b1) begin
            failures++; $display("FAIL pre_reset_load got=%h/%b exp=deadbeef/1", a_rdata, a_rvalid); end
        rst_a = 1'b1; #1;
        checks++; if (a_rvalid !== 1'b0) begin failures++; $display("FAIL async_rvalid got=%b exp=0", a_rvalid); end
        checks++; if (a_rdata !== 32'h0) begin failures++; $display("FAIL async_rdata got=%h exp=0", a_rdata); end
        checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL async_ready got=%b exp=0", a_ready); end
        @(posedge clk); #1; rst_a = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL half_sweep_ready got=%b exp=0", a_ready); end
        rst_a = 1'b1; #1;
        checks++; if (a_ready !== 1'b0 || a_rvalid !== 1'b0) begin
            failures++; $display("FAIL mid_sweep_reset ready=%b rvalid=%b exp=0", a_ready, a_rvalid); end
        @(posedge clk); #1; rst_a = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (i >= 15) begin
                checks++;
                if (a_ready !== (i == 16)) begin
                    failures++; $display("FAIL restart_ready edge=%0d got=%b exp=%b", i, a_ready, i == 16);
                end
            end
        end
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        checks++; if (a_rdata !== 32'h0 || a_rvalid !== 1'b1) begin
            failures++; $display("FAIL swept_word got=%h/%b exp=0/1", a_rdata, a_rvalid); end
        rst_a = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  sz;
        logic        sx;
        int unsigned ad;
        logic [31:0] wd;
        logic [31:0] exp;
        rst_b = 1'b0; #1;
        checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL nb_ready_before got=%b exp=0", b_ready); end
        @(posedge clk); #1;
        checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL nb_ready_first got=%b exp=1", b_ready); end
        for (int i = 0; i < 8; i++) begin
            sz = 2'($urandom_range(0, 2));
            sx = 1'($urandom_range(0, 1));
            ad = i * 8 + ((4 >> sz) == 4 ? 0 : $urandom_range(0, 3) & ~((1 << sz) - 1));
            wd = $urandom;
            m_store(sz, ad, wd);
            exp = m_load(sz, sx, ad);
            issue(1'b1, sz, 1'b0, ad, wd);
            checks++; if (b_rvalid !== 1'b0 || b_err !== 1'b0) begin
                failures++; $display("FAIL b2b_store pair=%0d rvalid=%b err=%b exp=0", i, b_rvalid, b_err); end
            issue(1'b0, sz, sx, ad, 32'h0);
            model_rd = exp;
            checks++; if (b_rvalid !== 1'b1 || b_err !== 1'b0) begin
                failures++; $display("FAIL b2b_flags pair=%0d rvalid=%b err=%b exp=1/0", i, b_rvalid, b_err); end
            checks++; if (b_rdata !== exp) begin
                failures++; $display("FAIL b2b_data pair=%0d got=%h exp=%h", i, b_rdata, exp); end
        end
    endtask

    task automatic test_random();
        logic        rq, w, sx, exp_rv, exp_er;
        logic [1:0]  sz;
        int unsigned ad;
        logic [31:0] wd;
        for (int i = 0; i < int'(DEPTH); i++) begin
            wd = $urandom;
            m_store(2'd2, i * 4, wd);
            issue(1'b1, 2'd2, 1'b0, i * 4, wd);
        end
        for (int c = 0; c < 300; c++) begin
            rq = ($urandom_range(0, 3) != 0);
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sx = 1'($urandom_range(0, 1));
            ad = $urandom_range(0, DEPTH * 4 + 7);
            wd = $urandom;
            exp_rv = 1'b0; exp_er = 1'b0;
            if (rq) begin
                if (m_bad(sz, ad)) exp_er = 1'b1;
                else if (w) m_store(sz, ad, wd);
                else begin model_rd = m_load(sz, sx, ad); exp_rv = 1'b1; end
            end
            req = rq; we = w; size = sz; sext = sx; addr = ad; wdata = wd;
            @(posedge clk); #1;
            req = 1'b0;
            checks++; if (b_rvalid !== exp_rv) begin
                failures++; $display("FAIL rand_rvalid cyc=%0d got=%b exp=%b", c, b_rvalid, exp_rv); end
            checks++; if (b_err !== exp_er) begin
                failures++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", c, b_err, exp_er); end
            checks++; if (b_rdata !== model_rd) begin
                failures++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", c, b_rdata, model_rd); end
        end
    endtask

    initial begin
        test_reset();
        test_lanes();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
